// File: rtl/seg7_scan_ctrl_if.sv
// Load/display interface of the seven-segment scan controller.
//   load        one-cycle strobe capturing value/dp/digit_en/blink_en
//   value       hex nibble per digit, digit i = value[4i+3:4i]
//   dp          decimal point on, per digit
//   digit_en    digit enabled, per digit
//   blink_en    digit blinks, per digit
//   lz_blank    leading-zero blanking enable (live)
//   AN          anode selects, active-low
//   cathodes    {dp,g,f,e,d,c,b,a}, active-low
//   frame_start one-cycle pulse at the start of each scan frame
//   pending     a loaded value awaits commit
// The master drives the load side; the controller is the slave.
interface seg7_scan_ctrl_if #(
    parameter int NUM_DIGITS = 8
);
    logic                    load;
    logic [4*NUM_DIGITS-1:0] value;
    logic [NUM_DIGITS-1:0]   dp;
    logic [NUM_DIGITS-1:0]   digit_en;
    logic [NUM_DIGITS-1:0]   blink_en;
    logic                    lz_blank;
    logic [NUM_DIGITS-1:0]   AN;
    logic [7:0]              cathodes;
    logic                    frame_start;
    logic                    pending;

    modport master (
        output load, value, dp, digit_en, blink_en, lz_blank,
        input  AN, cathodes, frame_start, pending
    );

    modport slave (
        input  load, value, dp, digit_en, blink_en, lz_blank,
        output AN, cathodes, frame_start, pending
    );
endinterface

// File: rtl/seg7_scan_ctrl.sv
// Multiplexed common-anode seven-segment display controller.
// Scans NUM_DIGITS digits, one slot of SCAN_CYC clocks each, with the first
// DEAD_CYC clocks of every slot blanked. New display contents are captured
// into a pending register set on bus.load and copied into the shadow set
// (which drives the display) only when the scan wraps back to digit 0.
// Ports:
//   clk_sys  system clock
//   rst      synchronous reset, active-low
//   bus      seg7_scan_ctrl_if slave modport (load inputs, display outputs)
module seg7_scan_ctrl #(
    parameter int NUM_DIGITS = 8,
    parameter int CLK_FREQ   = 100,
    parameter int REFRESH_HZ = 1000,
    parameter int SCAN_CYC   = CLK_FREQ * 1000000 / (REFRESH_HZ * NUM_DIGITS),
    parameter int DEAD_CYC   = 2,
    parameter int BLINK_CYC  = CLK_FREQ * 500000
) (
    input  logic            clk_sys,
    input  logic            rst,
    seg7_scan_ctrl_if.slave bus
);
    localparam int IW = $clog2(NUM_DIGITS);
    localparam int SW = $clog2(SCAN_CYC);
    localparam int BW = $clog2(BLINK_CYC);
    localparam logic [IW-1:0] IDX_LAST   = IW'(NUM_DIGITS - 1);
    localparam logic [SW-1:0] SLOT_LAST  = SW'(SCAN_CYC - 1);
    localparam logic [SW-1:0] DEAD_LAST  = SW'(DEAD_CYC);
    localparam logic [BW-1:0] BLINK_LAST = BW'(BLINK_CYC - 1);

    // Active-low segment pattern {g,f,e,d,c,b,a} for a hex nibble.
    function automatic logic [6:0] seg_decode(input logic [3:0] nib);
        case (nib)
            4'h0: seg_decode = 7'h40;
            4'h1: seg_decode = 7'h79;
            4'h2: seg_decode = 7'h24;
            4'h3: seg_decode = 7'h30;
            4'h4: seg_decode = 7'h19;
            4'h5: seg_decode = 7'h12;
            4'h6: seg_decode = 7'h02;
            4'h7: seg_decode = 7'h78;
            4'h8: seg_decode = 7'h00;
            4'h9: seg_decode = 7'h10;
            4'hA: seg_decode = 7'h08;
            4'hB: seg_decode = 7'h03;
            4'hC: seg_decode = 7'h46;
            4'hD: seg_decode = 7'h21;
            4'hE: seg_decode = 7'h06;
            default: seg_decode = 7'h0E;
        endcase
    endfunction

    logic [SW-1:0]           slot_q, slot_d;
    logic [IW-1:0]           idx_q, idx_d;
    logic [BW-1:0]           blink_q, blink_d;
    logic                    phase_on_q, phase_on_d;
    logic [4*NUM_DIGITS-1:0] sh_value_q, sh_value_d, pd_value_q, pd_value_d;
    logic [NUM_DIGITS-1:0]   sh_dp_q, sh_dp_d, pd_dp_q, pd_dp_d;
    logic [NUM_DIGITS-1:0]   sh_en_q, sh_en_d, pd_en_q, pd_en_d;
    logic [NUM_DIGITS-1:0]   sh_blink_q, sh_blink_d, pd_blink_q, pd_blink_d;
    logic                    pend_q, pend_d;
    logic [NUM_DIGITS-1:0]   an_q, an_d;
    logic [7:0]              cath_q, cath_d;
    logic                    fs_q, fs_d;

    logic                    slot_wrap, frame_wrap, visible;
    logic [NUM_DIGITS-1:0]   lz_mask;
    logic [3:0]              cur_nib;

    // Leading-zero mask: walking down from the top digit, a zero nibble is
    // blanked until the first enabled non-zero digit is seen. Digit 0 always
    // stays visible so a zero value still shows "0".
    always_comb begin : lz_scan
        logic       nz_above;
        logic [3:0] nib;
        nz_above = 1'b0;
        nib      = 4'h0;
        lz_mask  = '0;
        for (int i = NUM_DIGITS - 1; i >= 0; i--) begin
            nib        = sh_value_q[4*i +: 4];
            lz_mask[i] = (i != 0) && !nz_above && (nib == 4'h0);
            if (sh_en_q[i] && (nib != 4'h0)) begin
                nz_above = 1'b1;
            end
        end
    end

    always_comb begin
        slot_wrap  = (slot_q == SLOT_LAST);
        frame_wrap = slot_wrap && (idx_q == IDX_LAST);

        slot_d = slot_wrap ? '0 : slot_q + 1'b1;
        idx_d  = idx_q;
        if (slot_wrap) begin
            idx_d = (idx_q == IDX_LAST) ? '0 : idx_q + 1'b1;
        end

        blink_d    = (blink_q == BLINK_LAST) ? '0 : blink_q + 1'b1;
        phase_on_d = (blink_q == BLINK_LAST) ? ~phase_on_q : phase_on_q;

        // A load in the commit cycle lands in pending while the shadow takes
        // the previous pending contents, so the new value waits one frame.
        pd_value_d = bus.load ? bus.value    : pd_value_q;
        pd_dp_d    = bus.load ? bus.dp       : pd_dp_q;
        pd_en_d    = bus.load ? bus.digit_en : pd_en_q;
        pd_blink_d = bus.load ? bus.blink_en : pd_blink_q;
        pend_d     = bus.load | (pend_q & ~frame_wrap);

        sh_value_d = sh_value_q;
        sh_dp_d    = sh_dp_q;
        sh_en_d    = sh_en_q;
        sh_blink_d = sh_blink_q;
        if (frame_wrap && pend_q) begin
            sh_value_d = pd_value_q;
            sh_dp_d    = pd_dp_q;
            sh_en_d    = pd_en_q;
            sh_blink_d = pd_blink_q;
        end

        cur_nib = sh_value_q[{idx_q, 2'b00} +: 4];
        visible = sh_en_q[idx_q]
                  && !(sh_blink_q[idx_q] && !phase_on_q)
                  && !(bus.lz_blank && lz_mask[idx_q])
                  && (slot_q >= DEAD_LAST);

        an_d   = '1;
        cath_d = 8'hFF;
        if (visible) begin
            an_d[idx_q] = 1'b0;
            cath_d      = {~sh_dp_q[idx_q], seg_decode(cur_nib)};
        end

        fs_d = frame_wrap;
    end

    always_ff @(posedge clk_sys) begin
        if (!rst) begin
            slot_q     <= '0;
            idx_q      <= '0;
            blink_q    <= '0;
            phase_on_q <= 1'b1;
            sh_value_q <= '0;
            sh_dp_q    <= '0;
            sh_en_q    <= '0;
            sh_blink_q <= '0;
            pd_value_q <= '0;
            pd_dp_q    <= '0;
            pd_en_q    <= '0;
            pd_blink_q <= '0;
            pend_q     <= 1'b0;
            an_q       <= '1;
            cath_q     <= 8'hFF;
            fs_q       <= 1'b0;
        end else begin
            slot_q     <= slot_d;
            idx_q      <= idx_d;
            blink_q    <= blink_d;
            phase_on_q <= phase_on_d;
            sh_value_q <= sh_value_d;
            sh_dp_q    <= sh_dp_d;
            sh_en_q    <= sh_en_d;
            sh_blink_q <= sh_blink_d;
            pd_value_q <= pd_value_d;
            pd_dp_q    <= pd_dp_d;
            pd_en_q    <= pd_en_d;
            pd_blink_q <= pd_blink_d;
            pend_q     <= pend_d;
            an_q       <= an_d;
            cath_q     <= cath_d;
            fs_q       <= fs_d;
        end
    end

    assign bus.AN          = an_q;
    assign bus.cathodes    = cath_q;
    assign bus.frame_start = fs_q;
    assign bus.pending     = pend_q;
endmodule

// File: tb/tb_seg7_scan_ctrl.sv
module tb_seg7_scan_ctrl;
    localparam int ND = 4;

    logic clk_sys = 1'b0;
    logic rst;
    always #5 clk_sys = ~clk_sys;

    seg7_scan_ctrl_if #(.NUM_DIGITS(ND)) bus();

    seg7_scan_ctrl #(
        .NUM_DIGITS(ND),
        .SCAN_CYC  (4),
        .DEAD_CYC  (1),
        .BLINK_CYC (64)
    ) dut (
        .clk_sys(clk_sys),
        .rst    (rst),
        .bus    (bus.slave)
    );

    int          n_tests = 0;
    int          n_fail  = 0;
    logic [11:0] exp_q[$];

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_tests++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Queue one frame of expected {AN, cathodes}; 8'hFF marks a dark digit.
    task automatic push_frame(input logic [7:0] c0, input logic [7:0] c1,
                              input logic [7:0] c2, input logic [7:0] c3);
        logic [7:0] c[4];
        c[0] = c0; c[1] = c1; c[2] = c2; c[3] = c3;
        for (int d = 0; d < 4; d++) begin
            exp_q.push_back({4'hF, 8'hFF});
            for (int k = 0; k < 3; k++) begin
                if (c[d] == 8'hFF) exp_q.push_back({4'hF, 8'hFF});
                else               exp_q.push_back({~(4'b0001 << d), c[d]});
            end
        end
    endtask

    // Called on the frame_start cycle; the frame's outputs follow one cycle later.
    task automatic check_frame(input string tag);
        logic [11:0] e;
        for (int i = 0; i < 16; i++) begin
            @(negedge clk_sys);
            bus.load = 1'b0;
            if (exp_q.size() == 0) begin
                chk({tag, "_queue_empty"}, 32'd0, 32'd1);
            end else begin
                e = exp_q.pop_front();
                chk($sformatf("%s[%0d]", tag, i), {bus.AN, bus.cathodes}, e);
            end
        end
    endtask

    task automatic wait_fs();
        for (int k = 0; k < 40 && bus.frame_start !== 1'b1; k++) @(negedge clk_sys);
        chk("wait_frame_start", bus.frame_start, 1'b1);
    endtask

    task automatic arm_load(input logic [15:0] v, input logic [3:0] en,
                            input logic [3:0] dpv, input logic [3:0] bl);
        bus.value    = v;
        bus.digit_en = en;
        bus.dp       = dpv;
        bus.blink_en = bl;
        bus.load     = 1'b1;
    endtask

    task automatic do_load(input logic [15:0] v, input logic [3:0] en,
                           input logic [3:0] dpv, input logic [3:0] bl);
        arm_load(v, en, dpv, bl);
        @(negedge clk_sys);
        bus.load = 1'b0;
    endtask

    initial begin
        int fs_cnt;
        int last_fs;
        rst          = 1'b0;
        bus.load     = 1'b0;
        bus.value    = '0;
        bus.dp       = '0;
        bus.digit_en = '0;
        bus.blink_en = '0;
        bus.lz_blank = 1'b0;
        repeat (3) @(negedge clk_sys);
        chk("rst_an", bus.AN, 4'hF);
        chk("rst_cath", bus.cathodes, 8'hFF);
        chk("rst_fs", bus.frame_start, 1'b0);
        chk("rst_pend", bus.pending, 1'b0);
        rst = 1'b1;

        // Idle display, frame_start cadence
        fs_cnt  = 0;
        last_fs = -1;
        for (int c = 1; c <= 200; c++) begin
            @(negedge clk_sys);
            chk("idle_an", bus.AN, 4'hF);
            chk("idle_cath", bus.cathodes, 8'hFF);
            if (bus.frame_start === 1'b1) begin
                fs_cnt++;
                if (last_fs >= 0) chk("fs_period", c - last_fs, 16);
                last_fs = c;
            end
        end
        chk("fs_count", fs_cnt, 12);

        // Basic load and commit
        wait_fs();
        do_load(16'h12AF, 4'hF, 4'b0001, 4'h0);
        chk("pend_set", bus.pending, 1'b1);
        wait_fs();
        chk("pend_clr", bus.pending, 1'b0);
        push_frame(8'h0E, 8'h88, 8'hA4, 8'hF9);
        check_frame("frame_12AF");

        // Last load before the wrap wins
        do_load(16'h1111, 4'hF, 4'h0, 4'h0);
        do_load(16'h2222, 4'hF, 4'h0, 4'h0);
        wait_fs();
        chk("pend_clr2", bus.pending, 1'b0);
        push_frame(8'hA4, 8'hA4, 8'hA4, 8'hA4);
        check_frame("frame_2222");

        // Load exactly in the commit cycle
        do_load(16'h4567, 4'hF, 4'h0, 4'h0);
        repeat (14) @(negedge clk_sys);
        do_load(16'h89AB, 4'hF, 4'h0, 4'h0);
        chk("pend_keep", bus.pending, 1'b1);
        chk("fs_commit", bus.frame_start, 1'b1);
        push_frame(8'hF8, 8'h82, 8'h92, 8'h99);
        check_frame("frame_old");
        chk("pend_clr3", bus.pending, 1'b0);
        push_frame(8'h83, 8'h88, 8'h90, 8'h80);
        check_frame("frame_new");

        // Leading-zero blanking
        bus.lz_blank = 1'b1;
        do_load(16'h0050, 4'hF, 4'h0, 4'h0);
        wait_fs();
        push_frame(8'hC0, 8'h92, 8'hFF, 8'hFF);
        check_frame("lz_0050");
        do_load(16'h0000, 4'hF, 4'h0, 4'h0);
        wait_fs();
        push_frame(8'hC0, 8'hFF, 8'hFF, 8'hFF);
        check_frame("lz_0000");
        bus.lz_blank = 1'b0;

        // Reset in the middle of digit 2's slot, with a load still pending
        do_load(16'h1234, 4'hF, 4'h0, 4'h0);
        wait_fs();
        push_frame(8'h99, 8'hB0, 8'hA4, 8'hF9);
        check_frame("frame_1234");
        do_load(16'hFFFF, 4'hF, 4'hF, 4'h0);
        repeat (9) @(negedge clk_sys);
        chk("pre_rst_an", bus.AN, 4'b1011);
        chk("pre_rst_cath", bus.cathodes, 8'hA4);
        chk("pre_rst_pend", bus.pending, 1'b1);
        rst = 1'b0;
        @(negedge clk_sys);
        chk("mid_rst_an", bus.AN, 4'hF);
        chk("mid_rst_cath", bus.cathodes, 8'hFF);
        chk("mid_rst_pend", bus.pending, 1'b0);
        chk("mid_rst_fs", bus.frame_start, 1'b0);
        @(negedge clk_sys);
        rst = 1'b1;

        // Dark after reset; load for blink during frame 3, committed at frame 4
        for (int m = 1; m <= 3; m++) begin
            wait_fs();
            if (m == 3) arm_load(16'h8888, 4'hF, 4'h0, 4'b0100);
            push_frame(8'hFF, 8'hFF, 8'hFF, 8'hFF);
            check_frame("dark_after_rst");
        end

        // Blink phase flips every 64 cycles (4 frames) from reset release
        for (int m = 4; m <= 11; m++) begin
            wait_fs();
            push_frame(8'h80, 8'h80, (((m / 4) % 2) == 0) ? 8'h80 : 8'hFF, 8'h80);
            check_frame($sformatf("blink_f%0d", m));
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule

// File: doc/seg7_scan_ctrl.md
Name: seg7_scan_ctrl

Overview:
Parametrised multiplexed seven-segment display controller for the SoC's board-level display outputs (AN, cathodes). Drives NUM_DIGITS common-anode digits by time-multiplexed scanning, with hex decode, per-digit decimal point, enable and blink, and optional leading-zero blanking. A shadow/pending register pair prevents tearing: new values load at any time and are committed only at frame boundaries. A bus-attached peripheral wrapper or the top level drives its load interface.

Parameters:
NUM_DIGITS, 8, number of digits scanned (2..16)
CLK_FREQ, 100, system clock in MHz (integer)
REFRESH_HZ, 1000, full-frame refresh rate
SCAN_CYC, CLK_FREQ*1000000/(REFRESH_HZ*NUM_DIGITS), clocks per digit slot (minimum 2)
DEAD_CYC, 2, blanked clocks at the start of each slot (anti-ghosting), must be < SCAN_CYC
BLINK_CYC, CLK_FREQ*500000, clocks per blink half-period (1 Hz blink)

Ports:
clk_sys  in  1  system clock
rst  in  1  synchronous reset, active-low
load  in  1  one-cycle strobe: capture value/dp/digit_en/blink_en into pending
value  in  4*NUM_DIGITS  hex nibble per digit; digit i = value[4i+3:4i]
dp  in  NUM_DIGITS  decimal point on, per digit
digit_en  in  NUM_DIGITS  digit enabled, per digit
blink_en  in  NUM_DIGITS  digit blinks, per digit
lz_blank  in  1  leading-zero blanking enable (live, not shadowed)
AN  out  NUM_DIGITS  anode selects, active-low, registered
cathodes  out  8  {dp,g,f,e,d,c,b,a}, active-low, registered
frame_start  out  1  one-cycle pulse when the scan index returns to digit 0
pending  out  1  a loaded value awaits commit

Behaviour:
- Reset (rst=0 at a clk_sys edge): idx=0, slot counter=0, blink counter=0, blink phase=on, shadow and pending registers all 0 (all digits disabled), pending=0, AN all 1, cathodes=8'hFF, frame_start=0.
- Slot counter counts 0..SCAN_CYC-1 and wraps. On wrap, idx advances and wraps from NUM_DIGITS-1 to 0; frame_start=1 in the cycle after idx becomes 0.
- Commit: on the wrap where idx goes NUM_DIGITS-1 -> 0, shadow <= pending contents if pending=1; pending then clears.
- load: pending regs <= inputs; pending=1. Load while pending=1 overwrites it (last wins). Load in the commit cycle: commit uses the old pending contents; the new load stays pending (pending remains 1).
- Digit visibility for idx: shadow digit_en[idx]=1, AND not (blink_en[idx] and phase=off), AND not leading-zero blanked, AND slot counter >= DEAD_CYC.
- Leading-zero blanking (lz_blank=1): digit i is blanked if its nibble and all higher-index enabled-digit nibbles are 0; digit 0 is never blanked. A set dp does not stop blanking.
- Visible: AN[idx]=0, all other AN bits 1; cathodes = {~dp[idx], seg(nibble)}. Invisible: AN all 1, cathodes=8'hFF.
- Hex decode, cathodes with dp off: 0=C0 1=F9 2=A4 3=B0 4=99 5=92 6=82 7=F8 8=80 9=90 A=88 b=83 C=C6 d=A1 E=86 F=8E.
- Outputs are registered: one-cycle latency from idx/counter state to AN/cathodes.
- Blink counter counts 0..BLINK_CYC-1; phase toggles on wrap. It runs freely, independent of load.
- Reset mid-frame: outputs are blanked in the next cycle and the scan restarts at digit 0; pending contents are lost.

Test Plan:
(Overrides: NUM_DIGITS=4, SCAN_CYC=4, DEAD_CYC=1, BLINK_CYC=64.)
- Reset then release, no load -> AN=4'hF, cathodes=8'hFF for 200 cycles; frame_start pulses every 16 cycles.
- load value=16'h12AF, digit_en=4'hF, dp=4'b0001 -> pending=1 until the next frame wrap; then digit 0 shows cathodes=8'h0E with AN=4'b1110, digit 1 shows 8'h88, digit 2 shows 8'hA4, digit 3 shows 8'hF9. Each slot is 1 blank cycle followed by 3 lit cycles.
- Two loads before the wrap (16'h1111 then 16'h2222) -> after commit all digits show 8'hA4. A load exactly in the commit cycle -> the old pending value is displayed, pending stays 1, and the new value is displayed one frame later.
- lz_blank=1, value=16'h0050 -> digits 3 and 2 stay AN=1; digit 1 shows 8'h92; digit 0 shows 8'hC0. value=16'h0000 -> only digit 0 is lit, showing 8'hC0.
- blink_en=4'b0100 -> digit 2 is lit during 64-cycle on-phases and blank during 64-cycle off-phases; other digits are unaffected.
- rst=0 asserted mid-slot on digit 2 -> next cycle AN=4'hF and cathodes=8'hFF. After release, the display stays blank until a new load is committed.
